// File: rtl/multi_wave_generator.sv
// Phase-accumulator waveform generator: sawtooth, triangle, square and LFSR noise.
// Control inputs are shadowed and only take effect at a period boundary.
module multi_wave_generator #(
  parameter int OUT_W = 12,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [ACC_W-1:0] ftw,
  input  logic [OUT_W-1:0] duty,
  output logic [OUT_W-1:0] wave,
  output logic             wrap
);

  logic [ACC_W-1:0] r_acc;
  logic [1:0]       r_mode_a;
  logic [ACC_W-1:0] r_ftw_a;
  logic [OUT_W-1:0] r_duty_a;
  logic [15:0]      r_lfsr;

  logic [ACC_W:0]   w_sum;
  logic             w_carry;
  logic [OUT_W-1:0] w_phase;
  logic [OUT_W-1:0] w_tri_base;
  logic [OUT_W-1:0] w_sample;
  logic             w_lfsr_fb;
  logic             w_load;

  assign w_sum      = {1'b0, r_acc} + {1'b0, r_ftw_a};
  assign w_carry    = w_sum[ACC_W];
  assign w_phase    = r_acc[ACC_W-1 -: OUT_W];
  assign w_tri_base = {w_phase[OUT_W-2:0], 1'b0};
  assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  // A zero tuning word reloads every cycle so the block can never stall.
  assign w_load     = !en || (r_ftw_a == '0) || w_carry;

  always_comb begin
    w_sample = '0;
    case (r_mode_a)
      2'd0: w_sample = w_phase;
      2'd1: w_sample = w_phase[OUT_W-1] ? ~w_tri_base : w_tri_base;
      2'd2: w_sample = (w_phase < r_duty_a) ? '1 : '0;
      2'd3: w_sample = r_lfsr[15 -: OUT_W];
      default: w_sample = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_mode_a <= '0;
      r_ftw_a  <= '0;
      r_duty_a <= '0;
      r_lfsr   <= 16'hACE1;
      wave     <= '0;
      wrap     <= 1'b0;
    end else begin
      if (w_load) begin
        r_mode_a <= mode;
        r_ftw_a  <= ftw;
        r_duty_a <= duty;
      end
      if (en) begin
        r_acc <= w_sum[ACC_W-1:0];
        wave  <= w_sample;
        wrap  <= w_carry;
        if (w_carry) r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      end else begin
        wrap <= 1'b0;
      end
    end
  end

endmodule
